bcd_result_latch: RTL and testbench

Parametrised result register for the frequency counter display path. Captures the DIGITS-wide BCD count and overflow flag from the gate counter on a rising edge of the gate-control strobe, synchronised into the display clock domain. Holds the value for the scan/segment driver, generates a leading-zero blanking mask, supports display freeze and clear, and flags malformed BCD. Sits between the decade counter chain and the display multiplexer.

---
 rtl/fm_pkg.sv | 17 +
 rtl/bcd_result_latch_if.sv | 31 +++
 rtl/sync_rise.sv | 27 ++
 rtl/bcd_result_latch.sv | 164 ++++++++++++++++
 tb/tb_bcd_result_latch.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/fm_pkg.sv
// Shared types and constants for the frequency-meter display path.
package fm_pkg;

    localparam int BCD_W = 4;
    localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

    typedef enum logic [1:0] {
        EMPTY,
        SHOW,
        FROZEN
    } state_t;

    function automatic logic bcdBad(input logic [BCD_W-1:0] digit);
        return digit > BCD_MAX;
    endfunction

endpackage

// File: rtl/bcd_result_latch_if.sv
// Bus between gate-control/counter side and the result latch, plus display outputs.
interface bcd_result_latch_if
    import fm_pkg::*;
#(
    parameter int DIGITS = 8
);

    logic                      latch_req;
    logic                      hold;
    logic                      clear;
    logic [BCD_W*DIGITS-1:0]   num_in;
    logic                      over_in;
    logic [BCD_W*DIGITS-1:0]   num_out;
    logic                      over_out;
    logic [DIGITS-1:0]         blank_out;
    logic                      valid_out;
    logic                      upd_pulse;
    logic                      missed;
    logic                      bcd_err;

    modport master (
        output latch_req, hold, clear, num_in, over_in,
        input  num_out, over_out, blank_out, valid_out, upd_pulse, missed, bcd_err
    );

    modport slave (
        input  latch_req, hold, clear, num_in, over_in,
        output num_out, over_out, blank_out, valid_out, upd_pulse, missed, bcd_err
    );

endinterface

// File: rtl/sync_rise.sv
// Multi-flop synchroniser with rising-edge detect; all flops reset high so a
// request already asserted when reset releases is not mistaken for a new edge.
module sync_rise #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_i,
    output logic cap_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], async_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign cap_o = sync_q[STAGES-1] & ~prev_q;

endmodule

// File: rtl/bcd_result_latch.sv
// Display-side result register: captures the BCD count on a synchronised gate
// strobe, holds it for the scanner, and derives blanking and error flags.
module bcd_result_latch
    import fm_pkg::*;
#(
    parameter int DIGITS      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int BLANK_EN    = 1
) (
    input  logic               clk,
    input  logic               rst_n,
    bcd_result_latch_if.slave  bus
);

    localparam int W = BCD_W * DIGITS;
    localparam logic [DIGITS-1:0] BLANK_IDLE = (BLANK_EN != 0) ? ~DIGITS'(1) : {DIGITS{1'b0}};

    state_t            state_q, state_d;
    logic              cap;
    logic              doCapture, doClear, setMissed;

    logic [W-1:0]      num_q, num_d;
    logic              over_q, over_d;
    logic [DIGITS-1:0] blank_q, blank_d;
    logic              valid_q, valid_d;
    logic              upd_q, upd_d;
    logic              missed_q, missed_d;
    logic              err_q, err_d;

    logic [DIGITS-1:0] digitBad;
    logic [DIGITS-1:0] blankNext;
    logic              errNext;

    sync_rise #(
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk     (clk),
        .rst_n   (rst_n),
        .async_i (bus.latch_req),
        .cap_o   (cap)
    );

    for (genvar i = 0; i < DIGITS; i++) begin : g_digit
        assign digitBad[i] = bcdBad(bus.num_in[i*BCD_W +: BCD_W]);
    end
    assign errNext = |digitBad;

    // Digit i is a leading zero when every digit from i upward is zero.
    if (BLANK_EN != 0) begin : g_blank
        logic [DIGITS-1:0] leadZero;
        for (genvar i = 0; i < DIGITS; i++) begin : g_lead
            if (i == 0) begin : g_lsd
                assign leadZero[i] = 1'b0;
            end else begin : g_upper
                assign leadZero[i] = ~|bus.num_in[W-1:i*BCD_W];
            end
        end
        assign blankNext = (bus.over_in || errNext) ? {DIGITS{1'b0}} : leadZero;
    end else begin : g_noblank
        assign blankNext = {DIGITS{1'b0}};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (bus.clear) begin
            state_d = bus.hold ? FROZEN : EMPTY;
        end else begin
            case (state_q)
                EMPTY: begin
                    if (bus.hold) begin
                        state_d = FROZEN;
                    end else if (cap) begin
                        state_d = SHOW;
                    end
                end
                SHOW: begin
                    if (bus.hold) begin
                        state_d = FROZEN;
                    end
                end
                FROZEN: begin
                    if (!bus.hold) begin
                        state_d = (valid_q || cap) ? SHOW : EMPTY;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    // Hold is sampled at the capture edge, so a release coinciding with cap still captures.
    always_comb begin
        doClear   = bus.clear;
        doCapture = cap & ~bus.hold & ~bus.clear;
        setMissed = cap &  bus.hold & ~bus.clear;
    end

    always_comb begin
        num_d    = num_q;
        over_d   = over_q;
        blank_d  = blank_q;
        valid_d  = valid_q;
        missed_d = missed_q;
        err_d    = err_q;
        upd_d    = 1'b0;
        if (doClear) begin
            num_d    = '0;
            over_d   = 1'b0;
            blank_d  = BLANK_IDLE;
            valid_d  = 1'b0;
            missed_d = 1'b0;
            err_d    = 1'b0;
        end else begin
            if (doCapture) begin
                num_d   = bus.num_in;
                over_d  = bus.over_in;
                blank_d = blankNext;
                valid_d = 1'b1;
                err_d   = errNext;
                upd_d   = 1'b1;
            end
            if (setMissed) begin
                missed_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            num_q    <= '0;
            over_q   <= 1'b0;
            blank_q  <= BLANK_IDLE;
            valid_q  <= 1'b0;
            upd_q    <= 1'b0;
            missed_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            num_q    <= num_d;
            over_q   <= over_d;
            blank_q  <= blank_d;
            valid_q  <= valid_d;
            upd_q    <= upd_d;
            missed_q <= missed_d;
            err_q    <= err_d;
        end
    end

    assign bus.num_out   = num_q;
    assign bus.over_out  = over_q;
    assign bus.blank_out = blank_q;
    assign bus.valid_out = valid_q;
    assign bus.upd_pulse = upd_q;
    assign bus.missed    = missed_q;
    assign bus.bcd_err   = err_q;

endmodule

// File: tb/tb_bcd_result_latch.sv
// Bench for bcd_result_latch: directed vector table, corner sequences and a
// randomized run checked every cycle against a behavioural model.
module tb_bcd_result_latch;
    import fm_pkg::*;

    localparam int DIGITS  = 8;
    localparam int SYNC    = 2;
    localparam int DIGITS2 = 4;
    localparam int SYNC2   = 3;

    typedef struct packed {
        logic [31:0] num;
        logic        over;
        logic        hold;
        logic        clr;
        logic [31:0] expNum;
        logic        expOver;
        logic [7:0]  expBlank;
        logic        expValid;
        logic        expUpd;
        logic        expMissed;
        logic        expErr;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    bcd_result_latch_if #(.DIGITS(DIGITS))  bus();
    bcd_result_latch_if #(.DIGITS(DIGITS2)) bus2();

    bcd_result_latch #(.DIGITS(DIGITS), .SYNC_STAGES(SYNC), .BLANK_EN(1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    bcd_result_latch #(.DIGITS(DIGITS2), .SYNC_STAGES(SYNC2), .BLANK_EN(1)) dut2 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus2)
    );

    // Model state: what the display should show, independent of how the RTL gets there.
    logic [31:0] mNum;
    bit          mOver, mValid, mUpd, mMissed, mErr;
    bit          reqHist[$];

    function automatic bit anyBad(input logic [31:0] n);
        for (int i = 0; i < DIGITS; i++) begin
            if (n[4*i +: 4] > 4'd9) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic logic [7:0] blankOf(input logic [31:0] n, input bit over, input bit err);
        logic [7:0] m = 8'h00;
        if (over || err) return m;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            if (n[4*i +: 4] != 4'd0) break;
            m[i] = 1'b1;
        end
        return m;
    endfunction

    task automatic modelReset();
        mNum = '0; mOver = 0; mValid = 0; mUpd = 0; mMissed = 0; mErr = 0;
        reqHist = {};
        repeat (SYNC + 2) reqHist.push_back(1'b1);
    endtask

    // Capture takes effect SYNC edges after the first edge that sees latch_req high following a low sample.
    task automatic modelEdge();
        bit cap;
        reqHist.push_back(bus.latch_req);
        void'(reqHist.pop_front());
        cap = reqHist[1] && !reqHist[0];
        mUpd = 0;
        if (bus.clear) begin
            mNum = '0; mOver = 0; mValid = 0; mMissed = 0; mErr = 0;
        end else if (cap && !bus.hold) begin
            mNum = bus.num_in; mOver = bus.over_in; mValid = 1; mUpd = 1;
            mErr = anyBad(bus.num_in);
        end else if (cap && bus.hold) begin
            mMissed = 1;
        end
    endtask

    function automatic logic [63:0] dutVec();
        return 64'({bus.num_out, bus.over_out, bus.blank_out, bus.valid_out,
                    bus.upd_pulse, bus.missed, bus.bcd_err});
    endfunction

    function automatic logic [63:0] dut2Vec();
        return 64'({bus2.num_out, bus2.over_out, bus2.blank_out, bus2.valid_out,
                    bus2.upd_pulse, bus2.missed, bus2.bcd_err});
    endfunction

    function automatic logic [63:0] modelVec();
        return 64'({mNum, mOver, blankOf(mNum, mOver, mErr), mValid, mUpd, mMissed, mErr});
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic tick(input string name);
        @(posedge clk);
        modelEdge();
        #1;
        checkOutput(name, dutVec(), modelVec());
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        bus.num_in    = v.num;
        bus.over_in   = v.over;
        bus.hold      = v.hold;
        bus.latch_req = 1'b0;
        repeat (3) tick($sformatf("vec%0d_idle", idx));
        bus.latch_req = 1'b1;
        repeat (SYNC) tick($sformatf("vec%0d_sync", idx));
        bus.clear = v.clr;
        tick($sformatf("vec%0d_edge", idx));
        checkOutput($sformatf("vec%0d_table", idx), dutVec(),
                    64'({v.expNum, v.expOver, v.expBlank, v.expValid,
                         v.expUpd, v.expMissed, v.expErr}));
        bus.clear = 1'b0;
        tick($sformatf("vec%0d_after", idx));
        bus.hold = 1'b0;
        tick($sformatf("vec%0d_release", idx));
    endtask

    function automatic logic [31:0] randNum();
        logic [31:0] n = '0;
        int sig = $urandom_range(0, DIGITS);
        for (int i = 0; i < sig; i++) begin
            n[4*i +: 4] = ($urandom_range(0, 9) == 0) ? 4'($urandom_range(10, 15))
                                                      : 4'($urandom_range(0, 9));
        end
        return n;
    endfunction

    task automatic randTick();
        bus.hold  = ($urandom_range(0, 5) == 0);
        bus.clear = ($urandom_range(0, 11) == 0);
        tick("rand");
    endtask

    vec_t vecs[8];

    initial begin
        vecs[0] = '{32'h00012345, 1'b0, 1'b0, 1'b0, 32'h00012345, 1'b0, 8'b11100000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{32'h00000099, 1'b0, 1'b1, 1'b0, 32'h00012345, 1'b0, 8'b11100000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{32'h00000007, 1'b0, 1'b0, 1'b0, 32'h00000007, 1'b0, 8'b11111110, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[3] = '{32'h00000042, 1'b0, 1'b0, 1'b1, 32'h00000000, 1'b0, 8'b11111110, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4] = '{32'h0000A001, 1'b0, 1'b0, 1'b0, 32'h0000A001, 1'b0, 8'b00000000, 1'b1, 1'b1, 1'b0, 1'b1};
        vecs[5] = '{32'h00000000, 1'b1, 1'b0, 1'b0, 32'h00000000, 1'b1, 8'b00000000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{32'h90000000, 1'b0, 1'b0, 1'b0, 32'h90000000, 1'b0, 8'b00000000, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{32'h00000000, 1'b0, 1'b0, 1'b0, 32'h00000000, 1'b0, 8'b11111110, 1'b1, 1'b1, 1'b0, 1'b0};

        bus.latch_req = 1'b1; bus.hold = 1'b0; bus.clear = 1'b0;
        bus.num_in = '0; bus.over_in = 1'b0;
        bus2.latch_req = 1'b0; bus2.hold = 1'b0; bus2.clear = 1'b0;
        bus2.num_in = '0; bus2.over_in = 1'b0;
        modelReset();

        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset", dutVec(), modelVec());
        checkOutput("reset_d2", dut2Vec(), 64'({16'h0000, 1'b0, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0}));
        @(negedge clk);
        rst_n = 1'b1;

        // latch_req high through reset release must not count as an edge.
        repeat (10) tick("req_high_after_reset");

        bus2.num_in = 16'h0030;
        bus2.latch_req = 1'b1;
        repeat (SYNC2) tick("d2_sync");
        checkOutput("d2_before_edge3", dut2Vec(), 64'({16'h0000, 1'b0, 4'b1110, 1'b0, 1'b0, 1'b0, 1'b0}));
        tick("d2_edge3");
        checkOutput("d2_capture", dut2Vec(), 64'({16'h0030, 1'b0, 4'b1100, 1'b1, 1'b1, 1'b0, 1'b0}));
        tick("d2_after");
        checkOutput("d2_pulse_end", dut2Vec(), 64'({16'h0030, 1'b0, 4'b1100, 1'b1, 1'b0, 1'b0, 1'b0}));
        bus2.latch_req = 1'b0;
        repeat (3) tick("d2_low");
        bus2.num_in = 16'h0000;
        bus2.latch_req = 1'b1;
        repeat (SYNC2 + 1) tick("d2_zero");
        checkOutput("d2_zero_capture", dut2Vec(), 64'({16'h0000, 1'b0, 4'b1110, 1'b1, 1'b1, 1'b0, 1'b0}));

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i], i);
        end

        // Reset one edge into a capture window: the capture must be abandoned.
        bus.latch_req = 1'b0;
        bus.num_in = 32'h00000055;
        repeat (3) tick("mid_idle");
        bus.latch_req = 1'b1;
        tick("mid_edge0");
        #2;
        rst_n = 1'b0;
        modelReset();
        #1;
        checkOutput("mid_reset", dutVec(), modelVec());
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2 * SYNC + 2) tick("mid_post_reset");

        for (int seg = 0; seg < 60; seg++) begin
            bus.latch_req = 1'b0;
            bus.num_in  = randNum();
            bus.over_in = ($urandom_range(0, 7) == 0);
            repeat ($urandom_range(2, 5)) randTick();
            bus.latch_req = 1'b1;
            repeat ($urandom_range(SYNC + 2, SYNC + 5)) randTick();
        end
        bus.hold = 1'b0;
        bus.clear = 1'b0;
        repeat (3) tick("final");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
